// File: rtl/cl_pcis_rd_arb_pkg.sv
// Shared constants for the two-master pcis read arbiter: default widths,
// FSM state encoding and the position of the source tag in the shell-side ID.
package cl_pcis_arb_pkg;

   localparam int DEF_ID_W    = 6;
   localparam int DEF_ADDR_W  = 64;
   localparam int DEF_DATA_W  = 512;
   localparam int DEF_MAX_OUT = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   localparam logic [0:0] ST_IDLE = IDLE;
   localparam logic [0:0] ST_HOLD = HOLD;

   // The master index sits directly above the master's own ID bits.
   function automatic int src_tag_pos(input int id_w);
      return id_w;
   endfunction

endpackage

// File: rtl/cl_pcis_rd_arb_cnt.sv
// Per-master outstanding read-burst counter. Saturates at MAX_OUT and at zero;
// a decrement at zero is reported on underflow instead of wrapping.
module cl_pcis_rd_cnt
   import cl_pcis_arb_pkg::*;
#(
   parameter int MAX_OUT = DEF_MAX_OUT,
   parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full,
   output logic             underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: simultaneous inc and dec cancel out.
   always_comb begin
      cnt_d = cnt_q;
      case ({inc, dec})
         2'b10: begin
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         2'b01: begin
            if (cnt_q != CNT_ZERO) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt       = cnt_q;
   assign full      = (cnt_q == CNT_MAX);
   assign underflow = dec & (cnt_q == CNT_ZERO);

endmodule

// File: rtl/cl_pcis_rd_arb.sv
// Two-master AXI4 read arbiter onto the shared pcis port: round-robin AR grant
// with a registered AR slice, zero-latency R routing by the ID source tag.
module cl_pcis_rd_arb
   import cl_pcis_arb_pkg::*;
#(
   parameter int ID_W    = DEF_ID_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [7:0]        m0_arlen,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic              m0_rlast,
   output logic [ID_W-1:0]   m0_rid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [7:0]        m1_arlen,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic              m1_rlast,
   output logic [ID_W-1:0]   m1_rid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ID_W:0]     s_arid,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [7:0]        s_arlen,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [ID_W:0]     s_rid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   output logic              busy,
   output logic              rd_err
);

   localparam int SRC   = src_tag_pos(ID_W);
   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [0:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              s_arvalid_q, s_arvalid_d;
   logic [ID_W:0]     s_arid_q, s_arid_d;
   logic [ADDR_W-1:0] s_araddr_q, s_araddr_d;
   logic [7:0]        s_arlen_q, s_arlen_d;
   logic              rd_err_q, rd_err_d;

   logic              elig0, elig1, gnt_vld, gnt_sel;
   logic              full0, full1, uf0, uf1;
   logic              inc0, inc1, dec0, dec1;
   logic              r_src, rlast_hs;
   logic [CNT_W-1:0]  cnt0, cnt1;

   // Grant selection: a full master never wins; ties go to the one not granted last.
   always_comb begin
      elig0 = m0_arvalid & ~full0;
      elig1 = m1_arvalid & ~full1;
      if (elig0 && elig1) begin
         gnt_sel = ~last_grant_q;
      end else if (elig1) begin
         gnt_sel = 1'b1;
      end else begin
         gnt_sel = 1'b0;
      end
      gnt_vld = (state_q == ST_IDLE) & (elig0 | elig1);
   end

   assign m0_arready = gnt_vld & ~gnt_sel;
   assign m1_arready = gnt_vld &  gnt_sel;
   assign inc0       = m0_arvalid & m0_arready;
   assign inc1       = m1_arvalid & m1_arready;

   // FSM next state and AR slice load; payload is only captured on a grant.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      s_arvalid_d  = s_arvalid_q;
      s_arid_d     = s_arid_q;
      s_araddr_d   = s_araddr_q;
      s_arlen_d    = s_arlen_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld) begin
               state_d      = ST_HOLD;
               s_arvalid_d  = 1'b1;
               last_grant_d = gnt_sel;
               if (gnt_sel) begin
                  s_arid_d   = {1'b1, m1_arid};
                  s_araddr_d = m1_araddr;
                  s_arlen_d  = m1_arlen;
               end else begin
                  s_arid_d   = {1'b0, m0_arid};
                  s_araddr_d = m0_araddr;
                  s_arlen_d  = m0_arlen;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (s_arready) begin
               state_d     = ST_IDLE;
               s_arvalid_d = 1'b0;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            s_arvalid_d = 1'b0;
         end
      endcase
      rd_err_d = rd_err_q | uf0 | uf1;
   end

   // Arbiter state; last_grant resets to M1 so that M0 takes the first grant.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         s_arvalid_q  <= 1'b0;
         s_arid_q     <= {(ID_W + 1){1'b0}};
         s_araddr_q   <= {ADDR_W{1'b0}};
         s_arlen_q    <= 8'd0;
         rd_err_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         s_arvalid_q  <= s_arvalid_d;
         s_arid_q     <= s_arid_d;
         s_araddr_q   <= s_araddr_d;
         s_arlen_q    <= s_arlen_d;
         rd_err_q     <= rd_err_d;
      end
   end

   assign s_arvalid = s_arvalid_q;
   assign s_arid    = s_arid_q;
   assign s_araddr  = s_araddr_q;
   assign s_arlen   = s_arlen_q;
   assign rd_err    = rd_err_q;
   assign busy      = (state_q == ST_HOLD) | (cnt0 != {CNT_W{1'b0}}) | (cnt1 != {CNT_W{1'b0}});

   // R path is pure routing on the source tag, independent of counter state.
   assign r_src     = s_rid[SRC];
   assign m0_rvalid = s_rvalid & ~r_src;
   assign m1_rvalid = s_rvalid &  r_src;
   assign s_rready  = r_src ? m1_rready : m0_rready;
   assign m0_rid    = s_rid[ID_W-1:0];
   assign m1_rid    = s_rid[ID_W-1:0];
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m1_rresp  = s_rresp;
   assign m0_rlast  = s_rlast;
   assign m1_rlast  = s_rlast;
   assign rlast_hs  = s_rvalid & s_rready & s_rlast;
   assign dec0      = rlast_hs & ~r_src;
   assign dec1      = rlast_hs &  r_src;

   cl_pcis_rd_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_cnt0 (
      .clk       (aclk),
      .rst       (areset),
      .inc       (inc0),
      .dec       (dec0),
      .cnt       (cnt0),
      .full      (full0),
      .underflow (uf0)
   );

   cl_pcis_rd_cnt #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) u_cnt1 (
      .clk       (aclk),
      .rst       (areset),
      .inc       (inc1),
      .dec       (dec1),
      .cnt       (cnt1),
      .full      (full1),
      .underflow (uf1)
   );

endmodule

// File: tb/tb_cl_pcis_rd_arb.sv
// Directed bench for cl_pcis_rd_arb with MAX_OUT=2 so that counter saturation
// is reachable in a handful of grants.
module tb_cl_pcis_rd_arb;

   localparam int ID_W    = 6;
   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_arvalid, m0_arready, m1_arvalid, m1_arready;
   logic [ID_W-1:0]   m0_arid, m1_arid, m0_rid, m1_rid;
   logic [ADDR_W-1:0] m0_araddr, m1_araddr;
   logic [7:0]        m0_arlen, m1_arlen;
   logic              m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic [1:0]        m0_rresp, m1_rresp;
   logic              s_arvalid, s_arready;
   logic [ID_W:0]     s_arid, s_rid;
   logic [ADDR_W-1:0] s_araddr;
   logic [7:0]        s_arlen;
   logic              s_rvalid, s_rready, s_rlast;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;
   logic              busy, rd_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   cl_pcis_rd_arb #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
      .aclk(clk), .areset(rst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast),
      .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast),
      .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
      .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .busy(busy), .rd_err(rd_err)
   );

   task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reset spans one rising edge and is released on a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [1:0] exp_gnt [0:8];

   initial begin
      exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
      rst = 1'b1;
      m0_arvalid = 1'b0; m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_rready = 1'b0;
      m1_arvalid = 1'b0; m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_rready = 1'b0;
      s_arready = 1'b1; s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;

      // reset state
      @(negedge clk); #1;
      chk_vec("rst_s_arvalid", s_arvalid, 0);
      chk_vec("rst_s_arid", s_arid, 0);
      chk_vec("rst_busy", busy, 0);
      chk_vec("rst_rd_err", rd_err, 0);

      // single M0 burst
      rst = 1'b0;
      m0_arvalid = 1'b1; m0_arid = 6'h05; m0_araddr = 64'h1000; m0_arlen = 8'd3;
      #1;
      chk_vec("t1_m0_arready", m0_arready, 1);
      chk_vec("t1_s_arvalid_same_cycle", s_arvalid, 0);
      @(negedge clk); m0_arvalid = 1'b0; #1;
      chk_vec("t1_s_arvalid", s_arvalid, 1);
      chk_vec("t1_s_arid", s_arid, 64'h05);
      chk_vec("t1_s_araddr", s_araddr, 64'h1000);
      chk_vec("t1_s_arlen", s_arlen, 3);
      chk_vec("t1_cnt0", dut.cnt0, 1);
      @(negedge clk); #1;
      chk_vec("t1_s_arvalid_drop", s_arvalid, 0);
      chk_vec("t1_busy_out", busy, 1);
      for (int i = 0; i < 4; i++) begin
         s_rvalid = 1'b1; s_rid = 7'h05; s_rdata = 32'hD000 + i; s_rresp = 2'b00;
         s_rlast = (i == 3); m0_rready = 1'b1;
         #1;
         chk_vec("t1_m0_rvalid", m0_rvalid, 1);
         chk_vec("t1_m1_rvalid", m1_rvalid, 0);
         chk_vec("t1_m0_rdata", m0_rdata, 64'hD000 + i);
         chk_vec("t1_m0_rid", m0_rid, 64'h05);
         chk_vec("t1_m0_rlast", m0_rlast, (i == 3) ? 64'd1 : 64'd0);
         chk_vec("t1_s_rready", s_rready, 1);
         @(negedge clk);
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      chk_vec("t1_cnt0_end", dut.cnt0, 0);
      chk_vec("t1_busy_end", busy, 0);

      // both masters requesting: alternate grants, one per two cycles, until both full
      do_reset();
      m0_arvalid = 1'b1; m0_arid = 6'h11; m1_arvalid = 1'b1; m1_arid = 6'h22;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk_vec("t2_grant", {m1_arready, m0_arready}, exp_gnt[i]);
         if (i == 1) chk_vec("t2_s_arid_m0", s_arid, 64'h11);
         if (i == 3) chk_vec("t2_s_arid_m1", s_arid, 64'h62);
         @(negedge clk);
      end
      #1;
      chk_vec("t2_cnt0_full", dut.cnt0, 2);
      chk_vec("t2_cnt1_full", dut.cnt1, 2);

      // M1 saturated stalls while M0 frees a slot and wins; M1 wins after its own rlast
      s_rvalid = 1'b1; s_rid = 7'h11; s_rlast = 1'b1; m0_rready = 1'b1; #1;
      chk_vec("t3_both_full", {m1_arready, m0_arready}, 0);
      @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      chk_vec("t3_m1_stall_m0_win", {m1_arready, m0_arready}, 2'b01);
      @(negedge clk); #1;
      chk_vec("t3_s_arid_m0", s_arid, 64'h11);
      s_rvalid = 1'b1; s_rid = 7'h62; s_rlast = 1'b1; m1_rready = 1'b1; m0_rready = 1'b0; #1;
      chk_vec("t3_m1_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
      chk_vec("t3_m1_rid", m1_rid, 64'h22);
      chk_vec("t3_s_rready_m1", s_rready, 1);
      @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      chk_vec("t3_m1_win", {m1_arready, m0_arready}, 2'b10);
      @(negedge clk); m0_arvalid = 1'b0; m1_arvalid = 1'b0; #1;
      chk_vec("t3_s_arid_m1", s_arid, 64'h62);

      // backpressure in HOLD
      do_reset();
      s_arready = 1'b0;
      m1_arvalid = 1'b1; m1_arid = 6'h03; m1_araddr = 64'hABCD; m1_arlen = 8'd7; #1;
      chk_vec("t4_m1_sole", m1_arready, 1);
      @(negedge clk);
      m1_arvalid = 1'b0; m0_arvalid = 1'b1; m0_arid = 6'h09;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk_vec("t4_hold_valid", s_arvalid, 1);
         chk_vec("t4_hold_arid", s_arid, 64'h43);
         chk_vec("t4_hold_addr", s_araddr, 64'hABCD);
         chk_vec("t4_hold_len", s_arlen, 7);
         chk_vec("t4_no_grant", {m1_arready, m0_arready}, 0);
         if (k == 5) s_arready = 1'b1;
         @(negedge clk);
      end
      #1;
      chk_vec("t4_release", s_arvalid, 0);
      chk_vec("t4_m0_next", m0_arready, 1);
      @(negedge clk); m0_arvalid = 1'b0; #1;
      chk_vec("t4_s_arid_m0", s_arid, 64'h09);
      @(negedge clk);

      // simultaneous inc/dec, then an unexpected M1 rlast
      do_reset();
      m0_arvalid = 1'b1; m0_arid = 6'h01;
      @(negedge clk); m0_arvalid = 1'b0;
      @(negedge clk); #1;
      chk_vec("t5_cnt0_one", dut.cnt0, 1);
      m0_arvalid = 1'b1; s_rvalid = 1'b1; s_rid = 7'h01; s_rlast = 1'b1; m0_rready = 1'b1; #1;
      chk_vec("t5_same_cycle_hs", {s_rready, m0_arready}, 2'b11);
      @(negedge clk); m0_arvalid = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      chk_vec("t5_cnt0_kept", dut.cnt0, 1);
      chk_vec("t5_no_err", rd_err, 0);
      s_rvalid = 1'b1; s_rid = 7'h40; s_rlast = 1'b1; m1_rready = 1'b1;
      @(negedge clk); s_rvalid = 1'b0; s_rlast = 1'b0; #1;
      chk_vec("t5_rd_err", rd_err, 1);
      chk_vec("t5_cnt1_zero", dut.cnt1, 0);
      @(negedge clk); @(negedge clk); #1;
      chk_vec("t5_rd_err_sticky", rd_err, 1);

      // reset in the middle of HOLD
      s_arready = 1'b0; m0_arvalid = 1'b1; m0_arid = 6'h02;
      @(negedge clk); m0_arvalid = 1'b0; #1;
      chk_vec("t6_hold", s_arvalid, 1);
      #2 rst = 1'b1; #1;
      chk_vec("t6_async_arvalid", s_arvalid, 0);
      chk_vec("t6_cnt0", dut.cnt0, 0);
      chk_vec("t6_rd_err", rd_err, 0);
      chk_vec("t6_busy", busy, 0);
      chk_vec("t6_s_arid", s_arid, 0);
      @(negedge clk);
      rst = 1'b0; s_arready = 1'b1; m0_arvalid = 1'b1; m1_arvalid = 1'b1; #1;
      chk_vec("t6_first_grant", {m1_arready, m0_arready}, 2'b01);
      @(negedge clk); m0_arvalid = 1'b0; m1_arvalid = 1'b0; #1;
      chk_vec("t6_s_arid", s_arid, 64'h02);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cl_pcis_rd_arb.md
CL_PCIS_RD_ARB -- requirements
Module: cl_pcis_rd_arb

Interface
REQ-001 SHALL have parameter ID_W, default 6: master AXI4 ID width.
REQ-002 SHALL have parameter ADDR_W, default 64: AXI4 address width.
REQ-003 SHALL have parameter DATA_W, default 512: AXI4 read data width.
REQ-004 SHALL have parameter MAX_OUT, default 8: per-master outstanding-burst limit, range 1..255.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic rising-edge.
REQ-006 SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports mN_arvalid in / mN_arready out (1 bit each), for N=0,1: master AR handshake.
REQ-008 SHALL have ports mN_arid in (ID_W), mN_araddr in (ADDR_W), mN_arlen in (8), for N=0,1: master AR payload.
REQ-009 SHALL have ports mN_rvalid out (1), mN_rready in (1), mN_rlast out (1), for N=0,1: master R handshake.
REQ-010 SHALL have ports mN_rid out (ID_W), mN_rdata out (DATA_W), mN_rresp out (2), for N=0,1: master R payload.
REQ-011 SHALL have ports s_arvalid out / s_arready in (1 each), s_arid out (ID_W+1), s_araddr out (ADDR_W), s_arlen out (8): shared pcis AR port.
REQ-012 SHALL have ports s_rvalid in / s_rready out (1 each), s_rid in (ID_W+1), s_rdata in (DATA_W), s_rresp in (2), s_rlast in (1): shared pcis R port.
REQ-013 SHALL have port busy, output, 1 bit: high while state is HOLD or any outstanding count is nonzero.
REQ-014 SHALL have port rd_err, output, 1 bit: sticky flag for an unexpected R burst.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-016 SHALL define eligibility: master N is eligible when mN_arvalid=1 and cntN<MAX_OUT.
REQ-017 In IDLE with at least one eligible master, SHALL assert the winner's mN_arready combinationally in that cycle.
REQ-018 On that handshake, SHALL register {N, mN_arid}, araddr and arlen into the AR output register and enter HOLD.
REQ-019 SHALL drive s_arvalid=1 only in HOLD, one cycle after the master handshake.
REQ-020 SHALL hold all s_ar* outputs stable in HOLD until s_arready=1, then return to IDLE.
REQ-021 SHALL spend at least one IDLE cycle between consecutive grants: maximum one AR per two cycles.
REQ-022 SHALL keep mN_arready=0 in HOLD and for ineligible masters.
REQ-023 SHALL arbitrate round-robin via a last_grant register: if both masters are eligible, grant the one not equal to last_grant.
REQ-024 SHALL update last_grant only on an actual grant.
REQ-025 SHALL maintain per-master outstanding counter cntN, width clog2(MAX_OUT+1).
REQ-026 SHALL increment cntN on master N's AR handshake.
REQ-027 SHALL decrement cntN on an R handshake with s_rlast=1 and s_rid[ID_W]=N.
REQ-028 SHALL leave cntN unchanged when the increment and decrement events occur in the same cycle.
REQ-029 SHALL route R combinationally with zero latency: mN_rvalid = s_rvalid & (s_rid[ID_W]==N).
REQ-030 SHALL drive mN_rid = s_rid[ID_W-1:0]; mN_rdata, mN_rresp and mN_rlast pass through.
REQ-031 SHALL drive s_rready = m1_rready when s_rid[ID_W]=1, else m0_rready.
REQ-032 SHALL NOT gate R routing on count state.
REQ-033 On an rlast handshake for a master whose cnt is 0, SHALL hold cnt at 0 and set rd_err=1; rd_err clears only on reset.
REQ-034 SHALL NOT let a master with cnt=MAX_OUT win, even as the sole requester; the other master still wins if eligible.

Reset
REQ-035 While areset=1, SHALL force state=IDLE, s_arvalid=0, all s_ar* payload registers=0, cnt0=cnt1=0, last_grant=1 (M0 wins first), rd_err=0, busy=0.
REQ-036 On areset assertion mid-HOLD, SHALL drop s_arvalid asynchronously and abandon the pending AR; the system resets the shell side together.
REQ-037 SHALL start arbitration on the first aclk edge after areset deasserts.

Structure
REQ-038 SHALL place the default parameters, the FSM state enum (IDLE, HOLD) and the source-tag bit position in shared package cl_pcis_arb_pkg.
REQ-039 SHALL use one sub-module, cl_pcis_rd_cnt, instantiated once per master: saturating up/down outstanding counter with full/underflow flags.

Verification
REQ-040 Single M0 AR (arid=0x05, araddr=0x1000, arlen=3) with s_arready=1 -> s_arvalid one cycle later, s_arid=0x05, cnt0=1; 4 R beats with rid=0x05, rlast on the 4th -> m0 receives all beats, cnt0=0, busy=0.
REQ-041 Both masters hold arvalid continuously after reset, s_arready=1 -> grant order M0,M1,M0,M1, one grant every 2 cycles.
REQ-042 MAX_OUT=2, M1 issues 2 ARs with no R -> third M1 request stalls with m1_arready=0; M0 is still granted; one M1 rlast -> M1 granted next IDLE cycle.
REQ-043 s_arready low for 5 cycles in HOLD -> s_ar* stable throughout, no second grant, single handshake on release.
REQ-044 Same cycle: M0 AR handshake and M0 rlast handshake with cnt0=1 -> cnt0 stays 1; rlast with s_rid[ID_W]=1 while cnt1=0 -> rd_err=1, cnt1=0.
REQ-045 areset pulse during HOLD -> s_arvalid=0 immediately, counters 0, rd_err 0, M0 wins the first post-reset grant.
